// File: rtl/mantissa_align_rshift.sv
// mantissa_align_rshift
// Multi-cycle right-shift aligner for the FP adder datapath. A 24-bit
// significand is shifted right by a clamped exponent difference through a
// five-stage binary tree (one stage per clock). Guard/round/sticky are kept
// for the rounding unit.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high
//   start        request, sampled only while ready=1
//   dataA        significand to align (sampled with start)
//   shiftAmount  unsigned right-shift count (sampled with start)
//   ready        high when a new start will be accepted
//   done         one-cycle pulse, outputs valid from this cycle
//   result       aligned significand
//   guard        first bit below result LSB
//   round        second bit below result LSB
//   sticky       OR of all bits shifted out below round
module mantissa_align_rshift #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned SHW   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dataA,
    input  logic [SHW-1:0]   shiftAmount,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             guard,
    output logic             round,
    output logic             sticky
);

    localparam int unsigned WW = WIDTH + 3;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]    state;
    logic [1:0]    nextState;
    logic          accept;
    logic          lastStage;

    logic [2:0]    stage;
    logic [4:0]    amount;
    logic [4:0]    clampAmt;
    logic [WW-1:0] work;
    logic [WW-1:0] stageW;
    logic [4:0]    shiftN;
    logic [WW-1:0] lowMask;

    // Amounts of 27 or more push every bit into sticky, so 31 is an exact stand-in.
    assign clampAmt  = (shiftAmount > SHW'(31)) ? 5'd31 : shiftAmount[4:0];
    assign lastStage = (stage == 3'd4);

    // Next-state and accept decode.
    always_comb begin
        nextState = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = SHIFT;
                    accept    = 1'b1;
                end
            end
            SHIFT: begin
                if (lastStage) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    nextState = SHIFT;
                    accept    = 1'b1;
                end else begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // One tree stage: shift by 2^stage; bit 0 collects everything at or below old bit n.
    always_comb begin
        shiftN  = 5'(1) << stage;
        lowMask = (WW'(1) << (shiftN + 5'd1)) - WW'(1);
        stageW  = work;
        if (amount[0]) begin
            stageW    = work >> shiftN;
            stageW[0] = |(work & lowMask);
        end
    end

    // State register with registered handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            ready <= 1'b1;
            done  <= 1'b0;
        end else begin
            state <= nextState;
            ready <= (nextState != SHIFT);
            done  <= (nextState == DONE);
        end
    end

    // Datapath: load on accept, consume one amount bit per stage, publish on the last stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            work   <= '0;
            amount <= '0;
            stage  <= '0;
            result <= '0;
            guard  <= 1'b0;
            round  <= 1'b0;
            sticky <= 1'b0;
        end else if (accept) begin
            work   <= {dataA, 3'b000};
            amount <= clampAmt;
            stage  <= '0;
        end else if (state == SHIFT) begin
            work   <= stageW;
            amount <= amount >> 1;
            stage  <= stage + 3'd1;
            if (lastStage) begin
                {result, guard, round, sticky} <= stageW;
            end
        end
    end

endmodule

// File: tb/tb_mantissa_align_rshift.sv
// Self-checking bench for mantissa_align_rshift: directed spec cases,
// handshake/reset scenarios and randomized operations against a bit-level
// reference model of right shift with guard/round/sticky.
module tb_mantissa_align_rshift;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] dataA;
    logic [7:0]  shiftAmount;
    logic        ready;
    logic        done;
    logic [23:0] result;
    logic        guard;
    logic        round;
    logic        sticky;

    logic [26:0] obs;
    logic [26:0] prevOut;
    int          nCmp = 0;
    int          nBad = 0;

    mantissa_align_rshift #(.WIDTH(24), .SHW(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .dataA      (dataA),
        .shiftAmount(shiftAmount),
        .ready      (ready),
        .done       (done),
        .result     (result),
        .guard      (guard),
        .round      (round),
        .sticky     (sticky)
    );

    always #5 clock = ~clock;

    always_comb obs = {result, guard, round, sticky};

    // Reference: each input bit lands at position i-a; below-LSB positions feed G, R, then S.
    function automatic logic [26:0] model(input logic [23:0] d, input int a);
        logic [23:0] r  = '0;
        logic        g  = 1'b0;
        logic        rr = 1'b0;
        logic        s  = 1'b0;
        for (int i = 0; i < 24; i++) begin
            int pos = i - a;
            if (d[i]) begin
                if (pos >= 0)       r[pos] = 1'b1;
                else if (pos == -1) g = 1'b1;
                else if (pos == -2) rr = 1'b1;
                else                s = 1'b1;
            end
        end
        return {r, g, rr, s};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Caller is in cycle 0 (1ns after an edge); returns in the DONE cycle.
    task automatic runOp(input logic [23:0] d, input logic [7:0] a);
        logic [26:0] expOut;
        expOut      = model(d, int'(a));
        start       = 1'b1;
        dataA       = d;
        shiftAmount = a;
        step();
        start       = 1'b0;
        dataA       = 24'($urandom);
        shiftAmount = 8'($urandom);
        for (int c = 1; c <= 5; c++) begin
            nCmp++;
            if ({ready, done, obs} !== {2'b00, prevOut}) begin
                nBad++;
                $display("FAIL busy_c%0d d=%h a=%0d: got rdy/done/out=%b/%b/%h want 0/0/%h",
                         c, d, a, ready, done, obs, prevOut);
            end
            step();
        end
        nCmp++;
        if ({ready, done, obs} !== {2'b11, expOut}) begin
            nBad++;
            $display("FAIL done d=%h a=%0d: got rdy/done/res/grs=%b/%b/%h/%b want 1/1/%h/%b",
                     d, a, ready, done, result, obs[2:0], expOut[26:3], expOut[2:0]);
        end
        prevOut = expOut;
    endtask

    task automatic idleCycle();
        step();
        nCmp++;
        if ({ready, done, obs} !== {2'b10, prevOut}) begin
            nBad++;
            $display("FAIL idle: got rdy/done/out=%b/%b/%h want 1/0/%h", ready, done, obs, prevOut);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        dataA = 24'hFFFFFF;
        shiftAmount = 8'd3;
        step();
        step();
        reset = 1'b0;
        start = 1'b0;
        prevOut = '0;
        nCmp++;
        if ({ready, done, obs} !== {2'b10, 27'd0}) begin
            nBad++;
            $display("FAIL reset: got rdy/done/out=%b/%b/%h want 1/0/0", ready, done, obs);
        end
        idleCycle();
    endtask

    task automatic test_directed();
        runOp(24'h800000, 8'd0);   idleCycle();
        runOp(24'hFFFFFF, 8'd3);   idleCycle();
        runOp(24'h800001, 8'd1);   idleCycle();
        runOp(24'h800000, 8'd24);  idleCycle();
        runOp(24'h800000, 8'd25);  idleCycle();
        runOp(24'h800000, 8'd26);  idleCycle();
        runOp(24'h000001, 8'd200); idleCycle();
        runOp(24'h000000, 8'd200); idleCycle();
        runOp(24'hFFFFFF, 8'd31);  idleCycle();
        runOp(24'hFFFFFF, 8'd32);  idleCycle();
        runOp(24'hC00001, 8'd23);  idleCycle();
        runOp(24'hABCDEF, 8'd255); idleCycle();
    endtask

    task automatic test_ignored_start();
        logic [26:0] expOut;
        int doneCount;
        expOut      = model(24'h9A5F03, 7);
        start       = 1'b1;
        dataA       = 24'h9A5F03;
        shiftAmount = 8'd7;
        step();                 // cycle 1
        start = 1'b0;
        step();                 // cycle 2
        step();                 // cycle 3: stray request
        start       = 1'b1;
        dataA       = 24'h123456;
        shiftAmount = 8'd2;
        step();                 // cycle 4
        start = 1'b0;
        step();                 // cycle 5
        step();                 // cycle 6
        nCmp++;
        if ({ready, done, obs} !== {2'b11, expOut}) begin
            nBad++;
            $display("FAIL ignored_start_done: got rdy/done/out=%b/%b/%h want 1/1/%h",
                     ready, done, obs, expOut);
        end
        prevOut = expOut;
        doneCount = 0;
        for (int c = 7; c <= 14; c++) begin
            step();
            if (done) doneCount++;
        end
        nCmp++;
        if (doneCount !== 0) begin
            nBad++;
            $display("FAIL ignored_start_extra_done: got %0d extra done pulses want 0", doneCount);
        end
        idleCycle();
    endtask

    task automatic test_back_to_back();
        runOp(24'h800001, 8'd1);
        runOp(24'hFFFFFF, 8'd3);
        runOp(24'h7FFFFF, 8'd12);
        idleCycle();
    endtask

    task automatic test_reset_mid();
        int badCycles;
        start       = 1'b1;
        dataA       = 24'hABCDEF;
        shiftAmount = 8'd5;
        step();                 // cycle 1
        start = 1'b0;
        step();                 // cycle 2
        step();                 // cycle 3: reset with a competing start
        reset       = 1'b1;
        start       = 1'b1;
        dataA       = 24'hFFFFFF;
        shiftAmount = 8'd1;
        step();                 // cycle 4
        reset = 1'b0;
        start = 1'b0;
        prevOut = '0;
        nCmp++;
        if ({ready, done, obs} !== {2'b10, 27'd0}) begin
            nBad++;
            $display("FAIL reset_mid: got rdy/done/out=%b/%b/%h want 1/0/0", ready, done, obs);
        end
        badCycles = 0;
        for (int c = 5; c <= 12; c++) begin
            step();
            if (done || !ready) badCycles++;
        end
        nCmp++;
        if (badCycles !== 0) begin
            nBad++;
            $display("FAIL reset_mid_quiet: got %0d cycles with done or !ready want 0", badCycles);
        end
        runOp(24'h800000, 8'd2);
        idleCycle();
    endtask

    task automatic test_random();
        logic [23:0] d;
        logic [7:0]  a;
        for (int n = 0; n < 60; n++) begin
            d = 24'($urandom);
            if ($urandom_range(0, 1) == 1) d[23] = 1'b1;
            if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(0, 255));
            else                           a = 8'($urandom_range(0, 30));
            runOp(d, a);
            if ($urandom_range(0, 1) == 1) idleCycle();
        end
        idleCycle();
    endtask

    initial begin
        start       = 1'b0;
        reset       = 1'b1;
        dataA       = '0;
        shiftAmount = '0;
        prevOut     = '0;
        test_reset();
        test_directed();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
